// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, reads the combinational instruction memory and
// fills a single-entry IF/ID register handed to decode over a valid/ready handshake.
module fetch_stage #(
   parameter logic [63:0] RESET_PC  = 64'h0,
   parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
   input  logic        clk,
   input  logic        rst,
   output logic [63:0] pc_addr,
   input  logic [31:0] imem_instr,
   input  logic        imem_exc_en,
   input  logic [3:0]  imem_exc_code,
   input  logic [63:0] imem_exc_val,
   input  logic        br_en,
   input  logic [63:0] br_pc,
   input  logic        trap_en,
   input  logic [63:0] trap_pc,
   input  logic        id_ready,
   output logic        if_valid,
   output logic [63:0] if_pc,
   output logic [31:0] if_instr,
   output logic        if_exc_en,
   output logic [3:0]  if_exc_code,
   output logic [63:0] if_exc_val
);

   typedef enum logic {RUN, FAULT} state_t;

   state_t      state;
   logic [63:0] pc;
   logic        redirect;
   logic [63:0] target;
   logic        fire;

   assign pc_addr  = pc;
   assign redirect = trap_en || br_en;
   assign target   = trap_en ? trap_pc : br_pc;
   assign fire     = (state == RUN) && (!if_valid || id_ready) && !redirect;

   // Redirects flush the buffered entry; a faulting fetch parks the stage with pc held
   // until the trap redirect arrives.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= RUN;
         pc          <= RESET_PC;
         if_valid    <= 1'b0;
         if_pc       <= 64'h0;
         if_instr    <= NOP_INSTR;
         if_exc_en   <= 1'b0;
         if_exc_code <= 4'h0;
         if_exc_val  <= 64'h0;
      end else if (redirect) begin
         state    <= RUN;
         pc       <= target;
         if_valid <= 1'b0;
      end else if (fire) begin
         if_valid <= 1'b1;
         if_pc    <= pc;
         if (pc[1:0] != 2'b00) begin
            state       <= FAULT;
            if_instr    <= NOP_INSTR;
            if_exc_en   <= 1'b1;
            if_exc_code <= 4'h0;
            if_exc_val  <= pc;
         end else if (imem_exc_en) begin
            state       <= FAULT;
            if_instr    <= NOP_INSTR;
            if_exc_en   <= 1'b1;
            if_exc_code <= imem_exc_code;
            if_exc_val  <= imem_exc_val;
         end else begin
            pc          <= pc + 64'd4;
            if_instr    <= imem_instr;
            if_exc_en   <= 1'b0;
            if_exc_code <= 4'h0;
            if_exc_val  <= 64'h0;
         end
      end else if (id_ready) begin
         if_valid <= 1'b0;
      end
   end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the in-order RV64 core. Owns the program counter, drives the fetch address into the combinational instruction memory, and captures the returned word plus any fetch exception into the IF/ID pipeline register behind a valid/ready handshake to decode. Accepts branch and trap redirects, flushes the wrong-path entry, and parks after a fetch fault until the trap redirect arrives.

## Interface

- RESET_PC, 64'h0: PC loaded on reset.
- NOP_INSTR, 32'h00000013: word substituted for faulting or empty entries.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low (0 = reset).
- pc_addr  out  64  fetch address to instruction memory (the PC register).
- imem_instr  in  32  instruction word for pc_addr, same cycle.
- imem_exc_en  in  1  memory-side access fault for pc_addr.
- imem_exc_code  in  4  memory-side cause (1 = access fault).
- imem_exc_val  in  64  memory-side faulting address.
- br_en  in  1  branch/jump redirect from execute.
- br_pc  in  64  branch target.
- trap_en  in  1  trap/mret redirect from CSR unit.
- trap_pc  in  64  trap target.
- id_ready  in  1  decode accepts the IF/ID entry this cycle.
- if_valid  out  1  IF/ID entry valid.
- if_pc  out  64  PC of entry.
- if_instr  out  32  instruction of entry.
- if_exc_en  out  1  entry carries a fetch exception.
- if_exc_code  out  4  cause: 0 misaligned, 1 access fault.
- if_exc_val  out  64  faulting PC (mtval).

## Operation

- States: RUN (fetching), FAULT (exception entry issued; fetching halted).
- fire = state==RUN && (!if_valid || id_ready) && !redirect, where redirect = trap_en || br_en.
- Target select: trap_en has priority over br_en.
- Redirect (any state, overrides stall): pc <= target; if_valid <= 0; state <= RUN.
- fire with no fault: IF/ID <= {pc, imem_instr, exc=0}; if_valid <= 1; pc <= pc + 4 (64-bit, wraps modulo 2^64).
- fire with pc[1:0] != 0: IF/ID <= {pc, NOP_INSTR, exc_en=1, code=0, val=pc}; state <= FAULT; pc holds. Misalignment checked locally and takes priority over imem_exc_en.
- fire with imem_exc_en=1 (aligned): IF/ID <= {pc, NOP_INSTR, 1, imem_exc_code, imem_exc_val}; state <= FAULT; pc holds.
- if_valid && !id_ready && !redirect: all IF/ID fields and pc hold.
- FAULT, no redirect: no fetch; if_valid <= 0 once id_ready consumes the entry; pc holds.
- imem_exc_en sampled only on a fire cycle; memory toggling it between cycles has no effect.

## Timing

- Reset (rst=0 at edge): pc=RESET_PC, state=RUN, if_valid=0, if_pc=0, if_instr=NOP_INSTR, if_exc_en=0, if_exc_code=0, if_exc_val=0. Reset wins over every other input, including mid-stall and in FAULT.
- First entry: if_valid=1 one cycle after the first edge with rst=1.
- Fetch latency: 1 cycle, pc_addr to if_* registered. Throughput: 1 instr/cycle with id_ready=1.
- Redirect penalty: cycle after redirect edge has if_valid=0 and pc_addr=target; target entry valid the cycle after.
- IF/ID fields change only on fire, redirect or reset edges.
- Single-entry buffer; no combinational path from id_ready to if_* or pc_addr.

## Test plan

- Reset, then rst=1, id_ready=1, imem words at 0,4,8 -> if_pc 0,4,8 on consecutive cycles, if_instr matches, if_exc_en=0.
- Hold id_ready=0 for 3 cycles with if_valid=1 at if_pc=4 -> if_pc/if_instr unchanged, pc_addr stays 8; id_ready=1 -> next entry if_pc=8.
- br_en=1, br_pc=0x40 while stalled -> next cycle if_valid=0, pc_addr=0x40; following cycle if_pc=0x40, valid.
- trap_en=1 trap_pc=0x100 and br_en=1 br_pc=0x40 same cycle -> pc_addr=0x100, then if_pc=0x100.
- Free-run to pc=0x2000 with imem_exc_en=1 code 1 -> entry if_exc_en=1, code 1, val 0x2000, if_instr=0x00000013; no further fetches, pc_addr stays 0x2000 until trap_en with trap_pc=0x80 resumes at 0x80.
- br_pc=0x42 -> entry exc code 0, val 0x42, FAULT; then rst=0 while stalled in FAULT -> all outputs at reset values, state RUN.
